// File: rtl/ncl_ring_pkg.sv
// Shared dual-rail NCL definitions: rail encodings, the TH22 rail update and
// the binary-to-dual-rail encoder used for reset preloads.
package ncl_ring_pkg;

  localparam logic [1:0] RAIL_NULL = 2'b00;
  localparam logic [1:0] RAIL_D0   = 2'b01;
  localparam logic [1:0] RAIL_D1   = 2'b10;

  // Widest stage the encoder supports; wider stages need this raised.
  localparam int MAX_WIDTH = 32;

  // Gated C-element: sets when input and enable agree high, clears when both
  // are low, otherwise holds.
  function automatic logic th22_next(input logic r, input logic in, input logic en);
    return (in & en) | (r & (in | en));
  endfunction

  function automatic logic [2*MAX_WIDTH-1:0] encode_dual(input logic [MAX_WIDTH-1:0] value);
    logic [2*MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      v[2*i +: 2] = value[i] ? RAIL_D1 : RAIL_D0;
    end
    return v;
  endfunction

endpackage

// File: rtl/ncl_ring_osc_model_if.sv
// Observation and instrumentation bundle of the ring model. The master selects
// a stage; the slave (the ring) answers combinationally and reports counters.
interface ncl_ring_osc_model_if #(
  parameter int STAGES = 3,
  parameter int WIDTH  = 1,
  parameter int CNT_W  = 16
);
  localparam int SEL_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic [SEL_W-1:0]   obs_sel;
  logic [2*WIDTH-1:0] obs_rails;
  logic               obs_comp;
  logic [CNT_W-1:0]   wave_count;
  logic [CNT_W-1:0]   period;
  logic               period_valid;
  logic               deadlock;

  modport master (
    output obs_sel,
    input  obs_rails, obs_comp, wave_count, period, period_valid, deadlock
  );

  modport slave (
    input  obs_sel,
    output obs_rails, obs_comp, wave_count, period, period_valid, deadlock
  );

endinterface

// File: rtl/ncl_ring_stage.sv
// One ring stage: WIDTH gated TH22 rail pairs with a registered, hysteretic
// completion flag and a DATA/NULL reset preload.
module ncl_ring_stage
  import ncl_ring_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter bit               INIT_DATA  = 1'b0,
  parameter logic [WIDTH-1:0] INIT_VALUE = WIDTH'(1)
) (
  input  logic               clk,
  input  logic               init,
  input  logic               run,
  input  logic [2*WIDTH-1:0] in_rails,
  input  logic               en,
  output logic [2*WIDTH-1:0] rails,
  output logic               comp
);

  localparam logic [2*MAX_WIDTH-1:0] INIT_ENC    = encode_dual(MAX_WIDTH'(INIT_VALUE));
  localparam logic [2*WIDTH-1:0]     RESET_RAILS = INIT_DATA ? INIT_ENC[2*WIDTH-1:0] : '0;

  logic [2*WIDTH-1:0] rails_nxt;
  logic               full_nxt;
  logic               empty_nxt;

  always_comb begin
    rails_nxt = '0;
    full_nxt  = 1'b1;
    for (int i = 0; i < 2*WIDTH; i++) begin
      rails_nxt[i] = th22_next(rails[i], in_rails[i], en);
    end
    for (int i = 0; i < WIDTH; i++) begin
      full_nxt = full_nxt & (rails_nxt[2*i] | rails_nxt[2*i+1]);
    end
    empty_nxt = ~|rails_nxt;
  end

  // Completion follows the new rails in the same edge, holding while the
  // stage is part-way between NULL and DATA.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      rails <= RESET_RAILS;
      comp  <= INIT_DATA;
    end else if (run) begin
      rails <= rails_nxt;
      if (full_nxt)       comp <= 1'b1;
      else if (empty_nxt) comp <= 1'b0;
    end
  end

endmodule

// File: rtl/ncl_ring_osc_model.sv
// Cycle-level dual-rail NCL ring of STAGES stages with wavefront counting,
// period measurement on stage 0 and sticky deadlock detection.
module ncl_ring_osc_model
  import ncl_ring_pkg::*;
#(
  parameter int                STAGES         = 3,
  parameter int                WIDTH          = 1,
  parameter logic [STAGES-1:0] INIT_DATA_MASK = STAGES'(1),
  parameter logic [WIDTH-1:0]  INIT_VALUE     = WIDTH'(1),
  parameter int                CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 init,
  input  logic                 run,
  ncl_ring_osc_model_if.slave  obs
);

  localparam int SEL_W = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int RW    = 2*WIDTH;

  logic [STAGES-1:0][RW-1:0] rails;
  logic [STAGES-1:0][RW-1:0] rails_nxt;
  logic [STAGES-1:0]         comp;
  logic [STAGES-1:0]         changed;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int PREV = (k + STAGES - 1) % STAGES;
    localparam int NEXT = (k + 1) % STAGES;
    logic en;
    assign en = ~comp[NEXT];

    // Shadow of the stage update, used only to see what the edge will do.
    for (genvar i = 0; i < RW; i++) begin : g_rail
      assign rails_nxt[k][i] = th22_next(rails[k][i], rails[PREV][i], en);
    end
    assign changed[k] = (rails_nxt[k] != rails[k]);

    ncl_ring_stage #(
      .WIDTH     (WIDTH),
      .INIT_DATA (INIT_DATA_MASK[k]),
      .INIT_VALUE(INIT_VALUE)
    ) u_stage (
      .clk     (clk),
      .init    (init),
      .run     (run),
      .in_rails(rails[PREV]),
      .en      (en),
      .rails   (rails[k]),
      .comp    (comp[k])
    );
  end

  logic full0_nxt;
  logic edge0;

  always_comb begin
    full0_nxt = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      full0_nxt = full0_nxt & (rails_nxt[0][2*i] | rails_nxt[0][2*i+1]);
    end
  end

  assign edge0 = run & ~comp[0] & full0_nxt;

  logic [CNT_W-1:0] wave_count;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] interval;
  logic             period_valid;
  logic             seen_edge;
  logic             deadlock;

  // interval counts evaluated clocks only, restarting at 1 on each edge.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      wave_count   <= '0;
      period       <= '0;
      interval     <= '0;
      period_valid <= 1'b0;
      seen_edge    <= 1'b0;
      deadlock     <= 1'b0;
    end else if (run) begin
      if (!(|changed)) deadlock <= 1'b1;
      if (edge0) begin
        wave_count <= wave_count + 1'b1;
        interval   <= CNT_W'(1);
        seen_edge  <= 1'b1;
        if (seen_edge) begin
          period       <= interval;
          period_valid <= 1'b1;
        end
      end else if (interval != '1) begin
        interval <= interval + 1'b1;
      end
    end
  end

  logic [RW-1:0] sel_rails;
  logic          sel_comp;

  always_comb begin
    sel_rails = '0;
    sel_comp  = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (obs.obs_sel == SEL_W'(k)) begin
        sel_rails = rails[k];
        sel_comp  = comp[k];
      end
    end
  end

  assign obs.obs_rails    = sel_rails;
  assign obs.obs_comp     = sel_comp;
  assign obs.wave_count   = wave_count;
  assign obs.period       = period;
  assign obs.period_valid = period_valid;
  assign obs.deadlock     = deadlock;

endmodule

// File: tb/tb_ncl_ring_osc_model.sv
// Directed bench for the NCL ring model: four ring configurations share clock,
// init and run; expected ring states and counter values are hand-derived.
module tb_ncl_ring_osc_model;

  logic clk  = 1'b0;
  logic init = 1'b1;
  logic run  = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  ncl_ring_osc_model_if #(.STAGES(3), .WIDTH(1), .CNT_W(16)) i3 ();
  ncl_ring_osc_model_if #(.STAGES(3), .WIDTH(4), .CNT_W(16)) i4 ();
  ncl_ring_osc_model_if #(.STAGES(2), .WIDTH(1), .CNT_W(16)) i2 ();
  ncl_ring_osc_model_if #(.STAGES(5), .WIDTH(1), .CNT_W(16)) i5 ();

  ncl_ring_osc_model d3 (.clk(clk), .init(init), .run(run), .obs(i3));
  ncl_ring_osc_model #(.WIDTH(4), .INIT_VALUE(4'b1010)) d4 (.clk(clk), .init(init), .run(run), .obs(i4));
  ncl_ring_osc_model #(.STAGES(2), .INIT_DATA_MASK(2'b01)) d2 (.clk(clk), .init(init), .run(run), .obs(i2));
  ncl_ring_osc_model #(.STAGES(5), .INIT_DATA_MASK(5'b00001)) d5 (.clk(clk), .init(init), .run(run), .obs(i5));

  // Default ring, bit k = stage k holds DATA: DNN, DDN, NDN, NDD, NND, DND.
  logic [2:0] seq [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    init = 1'b1;
    run  = 1'b0;
    @(negedge clk);
    init = 1'b0;
    cyc  = 0;
  endtask

  task automatic check_state3(input string tag, input logic [2:0] exp);
    for (int k = 0; k < 3; k++) begin
      i3.obs_sel = 2'(k);
      #1;
      check({tag, "_rails"}, 32'(i3.obs_rails), exp[k] ? 32'h2 : 32'h0);
      check({tag, "_comp"},  32'(i3.obs_comp),  32'(exp[k]));
    end
    i3.obs_sel = '0;
  endtask

  task automatic check_wide(input int c);
    logic exp_comp;
    exp_comp = seq[c % 6][0];
    check("w4_comp", 32'(i4.obs_comp), 32'(exp_comp));
    if (exp_comp) check("w4_rails", 32'(i4.obs_rails), 32'h99);
  endtask

  task automatic check_counters3(input string tag, input int wave, input int per, input logic pv);
    check({tag, "_wave"},   32'(i3.wave_count),   32'(wave));
    check({tag, "_period"}, 32'(i3.period),       32'(per));
    check({tag, "_pvalid"}, 32'(i3.period_valid), 32'(pv));
  endtask

  initial begin
    i3.obs_sel = '0;
    i4.obs_sel = '0;
    i2.obs_sel = '0;
    i5.obs_sel = '0;

    // Free-running default ring plus the wide, two-stage and five-stage rings.
    do_reset();
    check_state3("reset", seq[0]);
    check_counters3("reset", 0, 0, 1'b0);
    check("reset_deadlock", 32'(i3.deadlock), 32'h0);
    check("w4_reset_rails", 32'(i4.obs_rails), 32'h99);
    i5.obs_sel = 3'd7;
    #1;
    check("s5_sel7_rails", 32'(i5.obs_rails), 32'h0);
    check("s5_sel7_comp",  32'(i5.obs_comp),  32'h0);
    i5.obs_sel = '0;
    run = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      step();
      check_state3("run", seq[c % 6]);
      check_wide(c);
      if (c == 1) begin
        check("s2_deadlock", 32'(i2.deadlock), 32'h1);
        check("s2_wave",     32'(i2.wave_count), 32'h0);
      end
      if (c == 4) check_counters3("c4", 0, 0, 1'b0);
      if (c == 5) check_counters3("c5", 1, 0, 1'b0);
      if (c == 11) begin
        check_counters3("c11", 2, 6, 1'b1);
        check("w4_period", 32'(i4.period), 32'h6);
      end
      if (c == 9) check("s5_pvalid_early", 32'(i5.period_valid), 32'h0);
      if (c >= 10 && c <= 30 && (c % 5) == 0) begin
        check("s5_period", 32'(i5.period),       32'h5);
        check("s5_pvalid", 32'(i5.period_valid), 32'h1);
        check("s5_wave",   32'(i5.wave_count),   32'(c / 5));
      end
    end
    check("s3_deadlock_100", 32'(i3.deadlock), 32'h0);
    check("s3_wave_100",     32'(i3.wave_count), 32'd16);
    check("s5_wave_100",     32'(i5.wave_count), 32'd20);
    check("s5_deadlock",     32'(i5.deadlock),   32'h0);
    check("s2_wave_end",     32'(i2.wave_count), 32'h0);
    check("s2_pvalid_end",   32'(i2.period_valid), 32'h0);
    check("s2_deadlock_end", 32'(i2.deadlock),   32'h1);

    // run low for ten clocks after clock 3.
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 3; c++) step();
    run = 1'b0;
    for (int c = 4; c <= 13; c++) begin
      step();
      check_state3("frozen", seq[3]);
      check("frozen_wave", 32'(i3.wave_count), 32'h0);
    end
    run = 1'b1;
    for (int c = 14; c <= 21; c++) begin
      step();
      check_state3("resume", seq[(c - 10) % 6]);
      if (c == 14) check("resume_wave14", 32'(i3.wave_count), 32'h0);
      if (c == 15) check_counters3("resume15", 1, 0, 1'b0);
      if (c == 21) check_counters3("resume21", 2, 6, 1'b1);
    end
    check("resume_deadlock", 32'(i3.deadlock), 32'h0);

    // init raised mid-run after clock 8.
    do_reset();
    run = 1'b1;
    for (int c = 1; c <= 8; c++) step();
    check("pre_init_wave", 32'(i3.wave_count), 32'h1);
    init = 1'b1;
    #1;
    check_state3("mid_init", seq[0]);
    check_counters3("mid_init", 0, 0, 1'b0);
    @(negedge clk);
    init = 1'b0;
    cyc  = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      check_state3("rerun", seq[c % 6]);
      if (c == 5)  check_counters3("rerun5", 1, 0, 1'b0);
      if (c == 11) check_counters3("rerun11", 2, 6, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
